// File: rtl/cfg_loader_pkg.sv
// Shared constants and state encoding for the configuration frame loader.
package cfg_loader_pkg;

  localparam logic [7:0] OPC_WRITE = 8'hF0;
  localparam logic [7:0] OPC_END   = 8'h0F;

  localparam int OPC_LSB = 24;
  localparam int COL_LSB = 16;
  localparam int FRM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISCARD,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

endpackage

// File: rtl/config_frame_loader_if.sv
// Word stream into the loader: valid/ready handshake, source is the master.
interface config_frame_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/frame_strobe_decoder.sv
// Registered (col,frame) -> one-hot latch enable; output clears asynchronously on reset.
module frame_strobe_decoder
  import cfg_loader_pkg::*;
#(
  parameter int COLS           = 4,
  parameter int FRAMES_PER_COL = 20
) (
  input  logic                           CLK,
  input  logic                           resetn,
  input  logic                           en_i,
  input  logic [7:0]                     col_i,
  input  logic [7:0]                     frm_i,
  output logic [COLS*FRAMES_PER_COL-1:0] strobe_o
);
  localparam int NSTRB = COLS * FRAMES_PER_COL;

  logic [NSTRB-1:0] hit;
  logic [NSTRB-1:0] strobe_q;

  // Each bit matches its own constant address, so at most one can be hot.
  for (genvar i = 0; i < NSTRB; i++) begin : g_dec
    assign hit[i] = (col_i == 8'(i / FRAMES_PER_COL)) &&
                    (frm_i == 8'(i % FRAMES_PER_COL));
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) strobe_q <= '0;
    else         strobe_q <= en_i ? hit : '0;
  end

  assign strobe_o = strobe_q;
endmodule

// File: rtl/config_frame_loader.sv
// Parses header + ROWS data words into a frame register, then strobes one latch column slice.
module config_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int FRAMES_PER_COL = 20,
  parameter int STROBE_CYCLES  = 2
) (
  input  logic                           CLK,
  input  logic                           resetn,
  config_frame_loader_if.slave           str_i,
  output logic [ROWS*WORD_W-1:0]         frame_data,
  output logic [COLS*FRAMES_PER_COL-1:0] frame_strobe,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [15:0]                    frames_written
);
  localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SC_W = $clog2(STROBE_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [RC_W-1:0]        row_cnt_q;
  logic [SC_W-1:0]        strb_cnt_q;
  logic [7:0]             col_q, frm_q;
  logic                   err_q, done_q;
  logic [15:0]            fw_cnt_q, fw_cnt_d;
  logic [ROWS*WORD_W-1:0] data_q;

  logic [7:0] hdr_opc, hdr_col, hdr_frm;
  logic       accept, in_ready, rows_last, strb_last, strb_en;
  logic       ld_addr, set_err, wr_row;
  logic       unused_hdr_bits;

  assign hdr_opc         = str_i.in_data[OPC_LSB +: 8];
  assign hdr_col         = str_i.in_data[COL_LSB +: 8];
  assign hdr_frm         = str_i.in_data[FRM_LSB +: 8];
  assign unused_hdr_bits = ^str_i.in_data[15:8];

  assign in_ready       = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_DISCARD);
  assign str_i.in_ready = in_ready;
  assign accept         = str_i.in_valid && in_ready;
  assign rows_last      = (row_cnt_q == RC_W'(ROWS - 1));
  assign strb_last      = (strb_cnt_q == SC_W'(STROBE_CYCLES - 1));
  // Enable is registered in the decoder, so it leads the visible strobe by one cycle.
  assign strb_en        = (state_q == S_SETUP) || ((state_q == S_STROBE) && !strb_last);

  always_comb begin
    state_d = state_q;
    ld_addr = 1'b0;
    set_err = 1'b0;
    wr_row  = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        if (hdr_opc == OPC_WRITE) begin
          if (({1'b0, hdr_col} < 9'(COLS)) && ({1'b0, hdr_frm} < 9'(FRAMES_PER_COL))) begin
            ld_addr = 1'b1;
            state_d = S_LOAD;
          end else begin
            set_err = 1'b1;
            state_d = S_DISCARD;
          end
        end else if (hdr_opc != OPC_END) begin
          set_err = 1'b1;
        end
      end
      S_LOAD: if (accept) begin
        wr_row = 1'b1;
        if (rows_last) state_d = S_SETUP;
      end
      S_DISCARD: if (accept && rows_last) state_d = S_IDLE;
      S_SETUP:   state_d = S_STROBE;
      S_STROBE:  if (strb_last) state_d = S_HOLD;
      S_HOLD:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign fw_cnt_d = ((state_q == S_HOLD) && (fw_cnt_q != 16'hFFFF)) ? fw_cnt_q + 16'd1 : fw_cnt_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      strb_cnt_q <= '0;
      col_q      <= '0;
      frm_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      fw_cnt_q   <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= (state_q == S_IDLE) ? '0 : (accept ? row_cnt_q + 1'b1 : row_cnt_q);
      strb_cnt_q <= (state_q == S_STROBE) ? strb_cnt_q + 1'b1 : '0;
      done_q     <= accept && (state_q == S_IDLE) && (hdr_opc == OPC_END);
      fw_cnt_q   <= fw_cnt_d;
      if (set_err) err_q <= 1'b1;
      if (ld_addr) begin
        col_q <= hdr_col;
        frm_q <= hdr_frm;
      end
      for (int r = 0; r < ROWS; r++)
        if (wr_row && (row_cnt_q == RC_W'(r)))
          data_q[r*WORD_W +: WORD_W] <= str_i.in_data[WORD_W-1:0];
    end
  end

  frame_strobe_decoder #(
    .COLS           (COLS),
    .FRAMES_PER_COL (FRAMES_PER_COL)
  ) u_dec (
    .CLK      (CLK),
    .resetn   (resetn),
    .en_i     (strb_en),
    .col_i    (col_q),
    .frm_i    (frm_q),
    .strobe_o (frame_strobe)
  );

  assign frame_data     = data_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
  assign err            = err_q;
  assign frames_written = fw_cnt_q;
endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: write, bad address, END, stalls, mid-strobe reset, saturation.
module tb_config_frame_loader;
  logic         CLK = 1'b0;
  logic         resetn;
  logic [127:0] frame_data;
  logic [79:0]  frame_strobe;
  logic         busy, done, err;
  logic [15:0]  frames_written;

  int total = 0;
  int bad   = 0;
  int multi_hot = 0;
  logic [79:0] strb_or = '0;

  config_frame_loader_if #(.WORD_W(32)) sif ();

  config_frame_loader dut (
    .CLK            (CLK),
    .resetn         (resetn),
    .str_i          (sif),
    .frame_data     (frame_data),
    .frame_strobe   (frame_strobe),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .frames_written (frames_written)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if ($countones(frame_strobe) > 1) multi_hot++;
    strb_or = strb_or | frame_strobe;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time exceeded, bound expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    int n = 0;
    @(negedge CLK);
    repeat (gap) @(negedge CLK);
    sif.in_data  = w;
    sif.in_valid = 1'b1;
    while (!sif.in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) chk("send_ready_timeout", 128'(sif.in_ready), 128'd1);
    @(posedge CLK);
    #1;
    sif.in_valid = 1'b0;
  endtask

  // Called right after the last data word is accepted; walks SETUP, STROBE x2, HOLD, IDLE.
  task automatic watch(input string tag, input int idx, input logic [127:0] d);
    logic [79:0] hot;
    hot = 80'd1 << idx;
    @(negedge CLK);
    chk({tag, "_setup_strobe"}, 128'(frame_strobe), 128'd0);
    chk({tag, "_setup_ready"},  128'(sif.in_ready), 128'd0);
    chk({tag, "_setup_data"},   frame_data, d);
    chk({tag, "_setup_busy"},   128'(busy), 128'd1);
    @(negedge CLK);
    chk({tag, "_strobe1"}, 128'(frame_strobe), 128'(hot));
    @(negedge CLK);
    chk({tag, "_strobe2"}, 128'(frame_strobe), 128'(hot));
    chk({tag, "_strobe2_data"}, frame_data, d);
    @(negedge CLK);
    chk({tag, "_hold_strobe"}, 128'(frame_strobe), 128'd0);
    chk({tag, "_hold_ready"},  128'(sif.in_ready), 128'd0);
    @(negedge CLK);
    chk({tag, "_idle_ready"},  128'(sif.in_ready), 128'd1);
    chk({tag, "_idle_busy"},   128'(busy), 128'd0);
  endtask

  task automatic wr_frame(input string tag, input logic [7:0] col, input logic [7:0] frm,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    send({8'hF0, col, 8'h00, frm}, 0);
    send(w0, 0);
    send(w1, 0);
    send(w2, 0);
    send(w3, 0);
    watch(tag, int'(col) * 20 + int'(frm), {w3, w2, w1, w0});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  128'(sif.in_ready), 128'd1);
    chk({tag, "_data"},   frame_data, 128'd0);
    chk({tag, "_strobe"}, 128'(frame_strobe), 128'd0);
    chk({tag, "_busy"},   128'(busy), 128'd0);
    chk({tag, "_done"},   128'(done), 128'd0);
    chk({tag, "_err"},    128'(err), 128'd0);
    chk({tag, "_fw"},     128'(frames_written), 128'd0);
  endtask

  localparam logic [127:0] D1 = 128'h44444444_33333333_22222222_11111111;

  initial begin
    resetn       = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    repeat (2) @(negedge CLK);
    chk_reset_vals("rst_in");
    resetn = 1'b1;
    @(negedge CLK);
    chk_reset_vals("rst_out");

    // 1) basic write col=1 frame=3 -> strobe bit 23
    wr_frame("t1", 8'd1, 8'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    chk("t1_fw", 128'(frames_written), 128'd1);
    chk("t1_err", 128'(err), 128'd0);

    // 2) out-of-range column and frame are discarded without strobing
    strb_or = '0;
    send(32'hF0040000, 0);
    @(negedge CLK);
    chk("t2_err", 128'(err), 128'd1);
    chk("t2_busy_discard", 128'(busy), 128'd1);
    for (int k = 0; k < 4; k++) send(32'hDEAD0000 + 32'(k), 0);
    send(32'hF0000014, 0);
    for (int k = 0; k < 4; k++) send(32'hBEEF0000 + 32'(k), 0);
    @(negedge CLK);
    chk("t2_data_kept", frame_data, D1);
    chk("t2_no_strobe", 128'(strb_or), 128'd0);
    chk("t2_fw_kept", 128'(frames_written), 128'd1);
    chk("t2_busy_idle", 128'(busy), 128'd0);
    wr_frame("t2_good", 8'd3, 8'd19, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004);
    chk("t2_fw", 128'(frames_written), 128'd2);
    chk("t2_err_sticky", 128'(err), 128'd1);

    // 3) END header -> one-cycle done, never busy
    send(32'h0F000000, 0);
    @(negedge CLK);
    chk("t3_done_hi", 128'(done), 128'd1);
    chk("t3_busy", 128'(busy), 128'd0);
    @(negedge CLK);
    chk("t3_done_lo", 128'(done), 128'd0);
    chk("t3_busy2", 128'(busy), 128'd0);

    // 4) stalls in LOAD; valid held high through SETUP/STROBE/HOLD
    send(32'hF0010003, 2);
    send(32'h11111111, 3);
    send(32'h22222222, 1);
    send(32'h33333333, 0);
    send(32'h44444444, 2);
    sif.in_data  = 32'h0F000000;
    sif.in_valid = 1'b1;
    watch("t4", 23, D1);
    @(posedge CLK);
    #1;
    sif.in_valid = 1'b0;
    @(negedge CLK);
    chk("t4_done", 128'(done), 128'd1);
    chk("t4_fw", 128'(frames_written), 128'd3);

    // 5) reset in the middle of the strobe
    send(32'hF0010003, 0);
    for (int k = 0; k < 4; k++) send(32'h55550000 + 32'(k), 0);
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_strobe_on", 128'(frame_strobe), 128'(80'd1 << 23));
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_strobe_async", 128'(frame_strobe), 128'd0);
    chk("t5_data_async", frame_data, 128'd0);
    @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    chk_reset_vals("t5_after");

    // 6) unknown opcode, then counter saturation
    send(32'h55010003, 0);
    @(negedge CLK);
    chk("t6_err", 128'(err), 128'd1);
    chk("t6_busy", 128'(busy), 128'd0);
    chk("t6_ready", 128'(sif.in_ready), 128'd1);
    chk("t6_fw0", 128'(frames_written), 128'd0);
    force dut.fw_cnt_q = 16'hFFFE;
    @(negedge CLK);
    release dut.fw_cnt_q;
    @(negedge CLK);
    chk("t6_fw_preset", 128'(frames_written), 128'hFFFE);
    wr_frame("t6_a", 8'd0, 8'd0, 32'h1, 32'h2, 32'h3, 32'h4);
    chk("t6_fw_max", 128'(frames_written), 128'hFFFF);
    wr_frame("t6_b", 8'd2, 8'd7, 32'h5, 32'h6, 32'h7, 32'h8);
    chk("t6_fw_sat", 128'(frames_written), 128'hFFFF);

    chk("onehot", 128'(multi_hot), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
